// File: rtl/set_arb_pkg.sv
// rtl/set_arb_pkg.sv - shared encodings and field widths for the set engine arbiter
package set_arb_pkg;

   localparam int CENT_W = 24;
   localparam int RAD_W  = 12;
   localparam int MODE_W = 2;
   localparam int CAND_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP,
      ST_DRAIN
   } state_t;

   typedef enum logic [1:0] {
      MODE_SINGLE = 2'b00,
      MODE_AND    = 2'b01,
      MODE_XOR    = 2'b10,
      MODE_EXACT2 = 2'b11
   } mode_t;

endpackage

// File: rtl/set_arb_rr_pick.sv
// rtl/set_arb_rr_pick.sv - round-robin picker: first requester at or after last_grant+1
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [IDW-1:0]   idx,
   output logic             any
);

   always_comb begin
      int k;
      k     = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      // Walk N_REQ positions starting just after the previous winner, wrapping at N_REQ.
      for (int i = 1; i <= N_REQ; i++) begin
         k = int'(last_grant) + i;
         if (k >= N_REQ) k = k - N_REQ;
         if (!any && req[k]) begin
            any      = 1'b1;
            grant[k] = 1'b1;
            idx      = IDW'(k);
         end
      end
   end

endmodule

// File: rtl/set_arb.sv
// rtl/set_arb.sv - round-robin job arbiter in front of a single set engine, with timeout
module set_arb
   import set_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int TMO   = 2047,
   localparam int IDW  = $clog2(N_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [CENT_W*N_REQ-1:0]  req_central,
   input  logic [RAD_W*N_REQ-1:0]   req_radius,
   input  logic [MODE_W*N_REQ-1:0]  req_mode,
   output logic [N_REQ-1:0]         ack,
   output logic                     done,
   output logic [CAND_W-1:0]        result,
   output logic [IDW-1:0]           result_id,
   output logic                     result_err,
   output logic                     set_en,
   output logic [CENT_W-1:0]        set_central,
   output logic [RAD_W-1:0]         set_radius,
   output logic [MODE_W-1:0]        set_mode,
   input  logic                     set_busy,
   input  logic                     set_valid,
   input  logic [CAND_W-1:0]        set_candidate
);

   localparam int TW = $clog2(TMO + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

   state_t           state;
   logic [IDW-1:0]   last_grant;
   logic [TW-1:0]    tmo_cnt;
   logic [N_REQ-1:0] pick_grant;
   logic [IDW-1:0]   pick_idx;
   logic             pick_any;
   logic             grant_now;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_pick (
      .req        (req),
      .last_grant (last_grant),
      .grant      (pick_grant),
      .idx        (pick_idx),
      .any        (pick_any)
   );

   // ack is combinational so the requester sees it while the arbiter is still in IDLE.
   assign grant_now = (state == ST_IDLE) && !set_busy && pick_any && !rst;
   assign ack       = grant_now ? pick_grant : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         last_grant  <= IDW'(N_REQ - 1);
         tmo_cnt     <= '0;
         done        <= 1'b0;
         result      <= '0;
         result_id   <= '0;
         result_err  <= 1'b0;
         set_en      <= 1'b0;
         set_central <= '0;
         set_radius  <= '0;
         set_mode    <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (grant_now) begin
                  last_grant  <= pick_idx;
                  set_central <= req_central[int'(pick_idx)*CENT_W +: CENT_W];
                  set_radius  <= req_radius[int'(pick_idx)*RAD_W +: RAD_W];
                  set_mode    <= req_mode[int'(pick_idx)*MODE_W +: MODE_W];
                  set_en      <= 1'b1;
                  tmo_cnt     <= '0;
                  state       <= ST_ISSUE;
               end
            end
            ST_ISSUE, ST_WAIT: begin
               // A result arriving on the timeout cycle still counts as a normal completion.
               if (state == ST_WAIT && set_valid) begin
                  done       <= 1'b1;
                  result     <= set_candidate;
                  result_id  <= last_grant;
                  result_err <= 1'b0;
                  state      <= ST_RESP;
               end else if (tmo_cnt == TMO_LAST) begin
                  done       <= 1'b1;
                  result     <= '0;
                  result_id  <= last_grant;
                  result_err <= 1'b1;
                  set_en     <= 1'b0;
                  state      <= ST_DRAIN;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
                  if (state == ST_ISSUE && set_busy) begin
                     set_en <= 1'b0;
                     state  <= ST_WAIT;
                  end
               end
            end
            ST_RESP: state <= ST_IDLE;
            ST_DRAIN: begin
               if (!set_busy) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_set_arb.sv
// tb/tb_set_arb.sv - bench for set_arb: job-lifecycle model, engine stub and directed scenarios
module tb_set_arb;
   import set_arb_pkg::*;

   localparam int N   = 4;
   localparam int TMO = 60;
   localparam int IDW = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req;
   logic [24*N-1:0]   req_central;
   logic [12*N-1:0]   req_radius;
   logic [2*N-1:0]    req_mode;
   logic [N-1:0]      ack;
   logic              done;
   logic [7:0]        result;
   logic [IDW-1:0]    result_id;
   logic              result_err;
   logic              set_en;
   logic [23:0]       set_central;
   logic [11:0]       set_radius;
   logic [1:0]        set_mode;
   logic              set_busy;
   logic              set_valid;
   logic [7:0]        set_candidate;

   set_arb #(.N_REQ(N), .TMO(TMO)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .req_central   (req_central),
      .req_radius    (req_radius),
      .req_mode      (req_mode),
      .ack           (ack),
      .done          (done),
      .result        (result),
      .result_id     (result_id),
      .result_err    (result_err),
      .set_en        (set_en),
      .set_central   (set_central),
      .set_radius    (set_radius),
      .set_mode      (set_mode),
      .set_busy      (set_busy),
      .set_valid     (set_valid),
      .set_candidate (set_candidate)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Job-lifecycle model: is a job outstanding, how old is it, has the engine taken it,
   // is the engine being drained after a timeout, and is this the done cycle.
   logic         mj_active, mj_took, m_drain, m_done, m_err, m_en;
   int           mj_age, m_last, m_id;
   logic [7:0]   m_res;
   logic [23:0]  m_cent;
   logic [11:0]  m_rad;
   logic [1:0]   m_mode;

   int g_idx[$], g_cyc[$];
   int d_id[$], d_res[$], d_err[$], d_cyc[$];
   logic [N-1:0] ack_s = '0;
   logic         en_s = 1'b0;

   function automatic int rr(input logic [N-1:0] r, input int last);
      for (int i = 1; i <= N; i++) begin
         int k;
         k = (last + i) % N;
         if (r[k]) return k;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int k;
      logic [N-1:0] ea;
      logic n_done;
      if (rst) begin
         mj_active = 0; mj_took = 0; m_drain = 0; m_done = 0; m_err = 0; m_en = 0;
         mj_age = 0; m_last = N - 1; m_id = 0; m_res = 0;
         m_cent = 0; m_rad = 0; m_mode = 0;
      end
      ea = '0;
      k  = -1;
      if (!rst && !mj_active && !m_drain && !m_done && !set_busy) begin
         k = rr(req, m_last);
         if (k >= 0) ea[k] = 1'b1;
      end
      chk("ack", ack, ea);
      chk("done", done, m_done);
      chk("result", result, m_res);
      chk("result_id", result_id, m_id);
      chk("result_err", result_err, m_err);
      chk("set_en", set_en, m_en);
      chk("set_central", set_central, m_cent);
      chk("set_radius", set_radius, m_rad);
      chk("set_mode", set_mode, m_mode);
      for (int i = 0; i < N; i++)
         if (ack[i]) begin g_idx.push_back(i); g_cyc.push_back(cyc); end
      if (done) begin
         d_id.push_back(int'(result_id)); d_res.push_back(int'(result));
         d_err.push_back(int'(result_err)); d_cyc.push_back(cyc);
      end
      if (!rst) begin
         n_done = 1'b0;
         if (k >= 0) begin
            mj_active = 1; mj_age = 0; mj_took = 0; m_en = 1; m_last = k;
            m_cent = req_central[k*24 +: 24];
            m_rad  = req_radius[k*12 +: 12];
            m_mode = req_mode[k*2 +: 2];
         end else if (mj_active) begin
            if (mj_took && set_valid) begin
               n_done = 1; m_res = set_candidate; m_err = 0; m_id = m_last; mj_active = 0;
            end else if (mj_age == TMO - 1) begin
               n_done = 1; m_res = 0; m_err = 1; m_id = m_last; mj_active = 0;
               m_drain = 1; m_en = 0;
            end else begin
               mj_age++;
               if (!mj_took && set_busy) begin mj_took = 1; m_en = 0; end
            end
         end else if (m_drain && !set_busy) begin
            m_drain = 0;
         end
         m_done = n_done;
      end
      ack_s = ack;
      en_s  = set_en;
   end

   // Engine stub and requesters; candidate chosen by central[23:21], which encodes the requester.
   logic [N-1:0] cont;
   logic [7:0]   cand_tab [8];
   logic         eng_busy = 1'b0, eng_never = 1'b0;
   int           eng_cnt = 0, eng_lat = 3, eng_hold = 0, fall_cyc = 0;

   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
         if (ack_s[k] && !cont[k]) req[k] = 1'b0;
      set_valid = 1'b0;
      if (eng_busy) begin
         eng_cnt++;
         if (eng_never) begin
            if (eng_cnt == eng_hold) eng_busy = 1'b0;
         end else begin
            if (eng_cnt == eng_lat) set_valid = 1'b1;
            if (eng_cnt == eng_lat + 1) eng_busy = 1'b0;
         end
         if (!eng_busy) fall_cyc = cyc;
      end else if (en_s) begin
         eng_busy = 1'b1;
         eng_cnt = 0;
         set_candidate = cand_tab[set_central[23:21]];
      end
      set_busy = eng_busy;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      eng_busy = 1'b0; set_busy = 1'b0; set_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
      rst = 1'b0;
   endtask

   task automatic wait_g(input string name, input int target, input int maxc);
      for (int i = 0; i < maxc && g_idx.size() < target; i++) step();
      chk(name, g_idx.size() >= target, 1);
   endtask

   task automatic wait_d(input string name, input int target, input int maxc);
      for (int i = 0; i < maxc && d_id.size() < target; i++) step();
      chk(name, d_id.size() >= target, 1);
   endtask

   initial begin
      int gb, db;
      int exp31 [4];
      req = '0; cont = '0;
      set_busy = 0; set_valid = 0; set_candidate = 0;
      req_central = {24'h6FEDCB, 24'h440660, 24'h2BCDEF, 24'h0ABCDE};
      req_radius  = {12'h444, 12'h333, 12'h222, 12'h111};
      req_mode    = {2'b11, 2'b00, 2'b10, 2'b01};
      cand_tab[0] = 8'h10; cand_tab[1] = 8'h21; cand_tab[2] = 8'h1D; cand_tab[3] = 8'h42;
      for (int i = 4; i < 8; i++) cand_tab[i] = 8'h00;
      do_reset(3);
      chk("reset_done", done, 0);
      chk("reset_set_en", set_en, 0);
      chk("reset_result", result, 0);

      // All four at once from reset: served 0,1,2,3, one at a time.
      gb = g_idx.size(); db = d_id.size();
      eng_lat = 3; req = 4'hF;
      wait_g("t2_grants", gb + 4, 400);
      wait_d("t2_dones", db + 4, 400);
      if (g_idx.size() >= gb + 4 && d_id.size() >= db + 4)
         for (int i = 0; i < 4; i++) begin
            chk("t2_order", g_idx[gb+i], i);
            chk("t2_done_id", d_id[db+i], i);
            chk("t2_done_res", d_res[db+i], cand_tab[i]);
            if (i < 3) chk("t2_serial", g_cyc[gb+i+1] > d_cyc[db+i], 1);
         end

      // Single job from requester 2.
      gb = g_idx.size(); db = d_id.size();
      eng_lat = 5; req[2] = 1'b1;
      wait_g("t1_grant", gb + 1, 50);
      wait_d("t1_done", db + 1, 100);
      if (d_id.size() > db && g_idx.size() > gb) begin
         chk("t1_ack_idx", g_idx[gb], 2);
         chk("t1_res", d_res[db], 8'h1D);
         chk("t1_id", d_id[db], 2);
         chk("t1_err", d_err[db], 0);
      end
      repeat (3) step();

      // Requester 1 alone sets last_grant = 1, then 1 and 3 continuously alternate.
      gb = g_idx.size(); db = d_id.size();
      req[1] = 1'b1;
      wait_d("t3_setup", db + 1, 100);
      gb = g_idx.size();
      cont[1] = 1'b1; cont[3] = 1'b1; req[1] = 1'b1; req[3] = 1'b1;
      wait_g("t3_grants", gb + 4, 400);
      cont = '0; req = '0;
      wait_d("t3_drain", g_idx.size(), 100);
      exp31 = '{3, 1, 3, 1};
      if (g_idx.size() >= gb + 4)
         for (int i = 0; i < 4; i++) chk("t3_order", g_idx[gb+i], exp31[i]);
      repeat (3) step();

      // Engine never answers: timeout, then no grant until busy falls.
      gb = g_idx.size(); db = d_id.size();
      eng_never = 1'b1; eng_hold = TMO + 15; req[0] = 1'b1;
      wait_g("t4_grant", gb + 1, 50);
      wait_d("t4_done", db + 1, TMO + 50);
      req[1] = 1'b1;
      wait_g("t4_regrant", gb + 2, 100);
      eng_never = 1'b0; eng_lat = 4;
      if (d_id.size() > db && g_idx.size() > gb + 1) begin
         chk("t4_err", d_err[db], 1);
         chk("t4_res", d_res[db], 0);
         chk("t4_id", d_id[db], 0);
         chk("t4_tmo_cycles", d_cyc[db] - (g_cyc[gb] + 1), TMO);
         chk("t4_regrant_idx", g_idx[gb+1], 1);
         chk("t4_regrant_cyc", g_cyc[gb+1], fall_cyc + 1);
      end
      wait_d("t4_done2", db + 2, 100);
      repeat (3) step();

      // Result strobe lands on the timeout cycle: normal completion wins.
      gb = g_idx.size(); db = d_id.size();
      eng_lat = TMO - 2; req[3] = 1'b1;
      wait_g("t5_grant", gb + 1, 50);
      wait_d("t5_done", db + 1, TMO + 20);
      if (d_id.size() > db && g_idx.size() > gb) begin
         chk("t5_err", d_err[db], 0);
         chk("t5_res", d_res[db], 8'h42);
         chk("t5_cycles", d_cyc[db] - (g_cyc[gb] + 1), TMO);
      end
      repeat (3) step();

      // Reset while the engine is working: job discarded, pointer back to requester 0.
      gb = g_idx.size(); db = d_id.size();
      eng_lat = 20; req[1] = 1'b1;
      wait_g("t6_grant", gb + 1, 50);
      repeat (5) step();
      do_reset(2);
      repeat (5) step();
      chk("t6_no_done", d_id.size(), db);
      gb = g_idx.size();
      eng_lat = 3; req[0] = 1'b1; req[2] = 1'b1;
      wait_g("t6_regrant", gb + 1, 50);
      if (g_idx.size() > gb) chk("t6_first_idx", g_idx[gb], 0);
      wait_d("t6_finish", d_id.size() + 2, 200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/set_arb.md
SET_ARB -- requirements
Module: set_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8); ID width IDW = clog2(N_REQ).
REQ-002 Parameter TMO, default 2047, cycles from job issue to timeout.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  N_REQ  per-requester job request, held high with its job fields until acked.
REQ-006 req_central  input  24*N_REQ  requester k's central in bits [24k+23:24k].
REQ-007 req_radius  input  12*N_REQ  requester k's radius in bits [12k+11:12k].
REQ-008 req_mode  input  2*N_REQ  requester k's mode in bits [2k+1:2k].
REQ-009 ack  output  N_REQ  one-hot, 1-cycle pulse: job k accepted.
REQ-010 done  output  1  1-cycle pulse: result_* valid.
REQ-011 result  output  8  candidate count of the finished job (0 on error).
REQ-012 result_id  output  IDW  requester index of the finished job.
REQ-013 result_err  output  1  finished job timed out.
REQ-014 set_en  output  1  engine start request.
REQ-015 set_central / set_radius / set_mode  output  24 / 12 / 2  engine job fields.
REQ-016 set_busy  input  1  engine busy.
REQ-017 set_valid  input  1  engine result strobe.
REQ-018 set_candidate  input  8  engine result.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP, DRAIN.
REQ-020 IDLE: when any req bit is high and set_busy = 0, the arbiter shall pick the first requester at or after (last_grant+1) mod N_REQ, latch its fields, pulse ack, record last_grant, and go to ISSUE the next cycle.
REQ-021 IDLE with set_busy = 1: no grant; requests wait.
REQ-022 ISSUE: set_en = 1, held every cycle until set_busy is sampled 1, then go to WAIT with set_en = 0 the next cycle.
REQ-023 set_central/radius/mode shall equal the latched job from ISSUE entry until leaving WAIT; they are unchanged in all other states.
REQ-024 WAIT: on set_valid = 1, capture set_candidate into result, go to RESP.
REQ-025 RESP: done = 1 for exactly one cycle, with result, result_id = granted index and result_err = 0, then go to IDLE.
REQ-026 The timeout counter shall clear on ISSUE entry and count every ISSUE/WAIT cycle; on reaching TMO, it shall force done = 1 with result_err = 1 and result = 0, then go to DRAIN.
REQ-027 DRAIN: set_en = 0, ignore set_valid, return to IDLE when set_busy = 0.
REQ-028 If set_valid and the timeout fall in the same cycle, set_valid wins (normal completion).
REQ-029 At most one job is outstanding; ack shall not pulse outside IDLE.
REQ-030 A requester dropping req before ack is legal; it is not granted.
REQ-031 result, result_id and result_err shall hold their last values between done pulses.
REQ-032 last_grant wraps from N_REQ-1 to 0.

Reset
REQ-033 Asynchronous rst shall force IDLE, ack = 0, done = 0, set_en = 0, result = 0, result_id = 0, result_err = 0, set_* fields = 0, last_grant = N_REQ-1 (requester 0 first), timeout = 0.
REQ-034 Reset mid-job shall discard the job without done; the engine shares rst.

Structure
REQ-035 Shared package holds the FSM state encoding, the field widths (24/12/2/8) and the mode encodings (00 single, 01 AND, 10 XOR, 11 exactly-two).
REQ-036 The round-robin picker shall be a sub-module rr_pick (req vector, last_grant in; one-hot grant and index out; combinational).

Verification
REQ-037 Bench: single job from requester 2, central 0x440660, radius 0x333, mode 00 -> ack[2] one cycle, set_en held until busy, done with result 29 (0x1D), id 2, err 0.
REQ-038 Bench: all four requesters request at once from reset -> grants in order 0,1,2,3, one outstanding at a time, four done pulses with matching ids.
REQ-039 Bench: requesters 1 and 3 request continuously after last_grant = 1 -> grant sequence 3,1,3,1 (no starvation).
REQ-040 Bench: engine stub never asserts valid -> done with err 1 and result 0 exactly TMO cycles after ISSUE entry; no ack until busy falls.
REQ-041 Bench: set_valid coincident with the timeout cycle -> result = set_candidate, err 0.
REQ-042 Bench: rst asserted during WAIT -> outputs at reset values immediately, no done; next request is granted to requester 0.
